// File: rtl/mcu_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcu_bus_pkg                                                        |
// | Command codes, FSM state type and defaults for the MCU bus engine. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mcu_bus_pkg;

   localparam logic [7:0] CMD_NOP          = 8'h00;
   localparam logic [7:0] CMD_GET_ID       = 8'h01;
   localparam logic [7:0] CMD_SET_ADDRESS  = 8'h02;
   localparam logic [7:0] CMD_WRITE_DATA   = 8'h03;
   localparam logic [7:0] CMD_CLEAR_STATUS = 8'h04;

   localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hAE;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDR    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_SEND_ID = 2'd3
   } mcu_bus_state_t;

endpackage
`default_nettype wire

// File: rtl/mcu_bus_strobe_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcu_bus_strobe_sync                                                |
// | Two-flop synchroniser for the MCU strobe plus rising-edge pulse.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mcu_bus_strobe_sync
   import mcu_bus_pkg::*;
(
   input  logic sysclk,
   input  logic rst_n,
   input  logic strobe_async,
   output logic strobe_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= strobe_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign strobe_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/mcu_bus_cmd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcu_bus_cmd_engine                                                 |
// | MCU parallel-bus command decoder with addressed write FIFO.        |
// | Option macro: MCU_BUS_AUTOINC_EN (address increments per write).   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mcu_bus_cmd_engine
   import mcu_bus_pkg::*;
#(
   parameter int         BUS_WIDTH  = 8,
   parameter int         ADDR_BYTES = 4,
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] DEVICE_ID  = DEVICE_ID_DEFAULT
)(
   input  logic                              sysclk,
   input  logic                              rst_n,
   input  logic                              mcu_strobe,
   input  logic                              mcu_cmd_data,
   input  logic [BUS_WIDTH-1:0]              mcu_data_in,
   output logic [BUS_WIDTH-1:0]              mcu_data_out,
   output logic                              mcu_data_oe,
   output logic                              cmd_strobe,
   output logic [BUS_WIDTH-1:0]              cmd_code,
   output logic                              wr_valid,
   input  logic                              wr_ready,
   output logic [ADDR_BYTES*BUS_WIDTH-1:0]   wr_addr,
   output logic [BUS_WIDTH-1:0]              wr_data,
   output logic                              overflow,
   output logic                              busy
);

   localparam int ADDR_WIDTH = ADDR_BYTES * BUS_WIDTH;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int BEAT_W     = $clog2(ADDR_BYTES) + 1;

   mcu_bus_state_t r_state, w_state_nxt;

   logic                  w_beat;
   logic                  w_cmd_dec;
   logic                  w_clr_ovf;
   logic                  w_addr_beat;
   logic                  w_addr_done;
   logic                  w_push;
   logic                  w_push_ok;
   logic                  w_pop;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] w_addr_full;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BEAT_W-1:0]     r_beat_cnt;
   logic [BUS_WIDTH-1:0]  r_cmd_code;
   logic                  r_cmd_strobe;
   logic                  r_overflow;

   logic [ADDR_WIDTH+BUS_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                r_wr_ptr;
   logic [PTR_W-1:0]                r_rd_ptr;
   logic [CNT_W-1:0]                r_count;

   mcu_bus_strobe_sync u_strobe_sync (
      .sysclk       (sysclk),
      .rst_n        (rst_n),
      .strobe_async (mcu_strobe),
      .strobe_rise  (w_beat)
   );

   // Earlier address beats sit in r_partial; the current beat completes the word.
   generate
      if (ADDR_BYTES > 1) begin : g_addr_multi
         logic [ADDR_WIDTH-BUS_WIDTH-1:0] r_partial;
         always_ff @(posedge sysclk) begin
            if (!rst_n)           r_partial <= '0;
            else if (w_addr_beat) r_partial <= w_addr_full[ADDR_WIDTH-BUS_WIDTH-1:0];
         end
         assign w_addr_full = {r_partial, mcu_data_in};
      end else begin : g_addr_single
         assign w_addr_full = mcu_data_in;
      end
   endgenerate

   always_ff @(posedge sysclk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_dec   = 1'b0;
      w_clr_ovf   = 1'b0;
      w_addr_beat = 1'b0;
      w_push      = 1'b0;
      if (w_beat) begin
         if (r_state == ST_SEND_ID) begin
            // The beat that ends ID readback is swallowed, whatever its kind.
            w_state_nxt = ST_IDLE;
         end else if (!mcu_cmd_data) begin
            w_cmd_dec = 1'b1;
            if (mcu_data_in == BUS_WIDTH'(CMD_GET_ID))           w_state_nxt = ST_SEND_ID;
            else if (mcu_data_in == BUS_WIDTH'(CMD_SET_ADDRESS)) w_state_nxt = ST_ADDR;
            else if (mcu_data_in == BUS_WIDTH'(CMD_WRITE_DATA))  w_state_nxt = ST_WRITE;
            else begin
               w_state_nxt = ST_IDLE;
               w_clr_ovf   = (mcu_data_in == BUS_WIDTH'(CMD_CLEAR_STATUS));
            end
         end else begin
            case (r_state)
               ST_ADDR: begin
                  w_addr_beat = 1'b1;
                  if (w_addr_done) w_state_nxt = ST_IDLE;
               end
               ST_WRITE: w_push = 1'b1;
               default:  w_push = 1'b0;
            endcase
         end
      end
   end

   assign w_addr_done = (r_beat_cnt == BEAT_W'(ADDR_BYTES - 1));

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop     = wr_valid && wr_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_beat_cnt   <= '0;
         r_cmd_code   <= '0;
         r_cmd_strobe <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_cmd_strobe <= w_cmd_dec;
         if (w_cmd_dec) begin
            r_cmd_code <= mcu_data_in;
            r_beat_cnt <= '0;
         end else if (w_addr_beat) begin
            if (w_addr_done) begin
               r_beat_cnt <= '0;
               r_addr     <= w_addr_full;
            end else begin
               r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
         end
`ifdef MCU_BUS_AUTOINC_EN
         if (w_push_ok) r_addr <= r_addr + ADDR_WIDTH'(1);
`endif
         if (w_clr_ovf)                r_overflow <= 1'b0;
         else if (w_push && !w_push_ok) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= {r_addr, mcu_data_in};
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign wr_valid            = (r_count != '0);
   assign {wr_addr, wr_data}  = wr_valid ? r_mem[r_rd_ptr] : '0;
   assign mcu_data_oe         = (r_state == ST_SEND_ID);
   assign mcu_data_out        = mcu_data_oe ? BUS_WIDTH'(DEVICE_ID) : '0;
   assign cmd_strobe          = r_cmd_strobe;
   assign cmd_code            = r_cmd_code;
   assign overflow            = r_overflow;
   assign busy                = (r_state != ST_IDLE) || wr_valid;

endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_cmd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mcu_bus_cmd_engine                                              |
// | Directed vector table plus multi-cycle sequences, FIFO scoreboard. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mcu_bus_cmd_engine;

   logic        sysclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mcu_strobe = 1'b0;
   logic        mcu_cmd_data = 1'b0;
   logic [7:0]  mcu_data_in = 8'h00;
   logic [7:0]  mcu_data_out;
   logic        mcu_data_oe;
   logic        cmd_strobe;
   logic [7:0]  cmd_code;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        overflow;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int n_hi = 0;
   int n_rise = 0;
   logic prev_cs = 1'b0;
   logic [39:0] exp_q[$];

   mcu_bus_cmd_engine dut (
      .sysclk       (sysclk),
      .rst_n        (rst_n),
      .mcu_strobe   (mcu_strobe),
      .mcu_cmd_data (mcu_cmd_data),
      .mcu_data_in  (mcu_data_in),
      .mcu_data_out (mcu_data_out),
      .mcu_data_oe  (mcu_data_oe),
      .cmd_strobe   (cmd_strobe),
      .cmd_code     (cmd_code),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .overflow     (overflow),
      .busy         (busy)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      logic        cd;
      logic [7:0]  d;
      logic [7:0]  code;
      logic        oe;
      logic [7:0]  dout;
      logic        ovf;
      logic        bsy;
      int          pulses;
      logic        beat;
      logic [31:0] a_inc;
      logic [31:0] a_hold;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sel(input logic [31:0] a_inc, input logic [31:0] a_hold);
`ifdef MCU_BUS_AUTOINC_EN
      return a_inc;
`else
      return a_hold;
`endif
   endfunction

   // Pop scoreboard and command-strobe pulse counters, sampled mid-cycle.
   always @(negedge sysclk) begin
      if (cmd_strobe) n_hi++;
      if (cmd_strobe && !prev_cs) n_rise++;
      prev_cs = cmd_strobe;
      if (rst_n && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) check("unexpected_beat", {wr_addr, wr_data}, 40'h0);
         else check("beat", {wr_addr, wr_data}, exp_q.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic cd, input logic [7:0] d, input logic [7:0] code,
                      input logic oe, input logic [7:0] dout, input logic ovf, input logic bsy,
                      input int pulses, input logic beat, input logic [31:0] a_inc,
                      input logic [31:0] a_hold);
      vt.push_back('{cd, d, code, oe, dout, ovf, bsy, pulses, beat, a_inc, a_hold});
   endtask

   task automatic xfer(input logic cd, input logic [7:0] d);
      @(posedge sysclk); #1;
      mcu_cmd_data = cd; mcu_data_in = d; mcu_strobe = 1'b1;
      repeat (5) @(posedge sysclk);
      #1 mcu_strobe = 1'b0;
      repeat (5) @(posedge sysclk);
      @(negedge sysclk);
   endtask

   // Data beat with wr_ready high only in the detect cycle, so push and pop coincide.
   task automatic xfer_sync_pop(input logic [7:0] d);
      @(posedge sysclk); #1;
      mcu_cmd_data = 1'b1; mcu_data_in = d; mcu_strobe = 1'b1;
      repeat (2) @(posedge sysclk);
      #1 wr_ready = 1'b1;
      @(posedge sysclk);
      #1 wr_ready = 1'b0;
      repeat (3) @(posedge sysclk);
      #1 mcu_strobe = 1'b0;
      repeat (5) @(posedge sysclk);
      @(negedge sysclk);
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || wr_valid) && cyc < 100) begin
         @(negedge sysclk);
         cyc++;
      end
      check(name, {31'd0, (exp_q.size() != 0 || wr_valid)}, 64'd0);
   endtask

   initial begin
      logic [31:0] base;
      int h0, r0;

      // Table: GET_ID, SET_ADDRESS, WRITE, unknown/ignored, abort, wrap.
      add(0, 8'h01, 8'h01, 1, 8'hAE, 0, 1, 1, 0, 0, 0);
      add(1, 8'h55, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(0, 8'h02, 8'h02, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      add(1, 8'h12, 8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 0);
      add(1, 8'h34, 8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 0);
      add(1, 8'h56, 8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 0);
      add(1, 8'h78, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(0, 8'h03, 8'h03, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      add(1, 8'hAA, 8'h03, 0, 8'h00, 0, 1, 0, 1, 32'h12345678, 32'h12345678);
      add(1, 8'hBB, 8'h03, 0, 8'h00, 0, 1, 0, 1, 32'h12345679, 32'h12345678);
      add(0, 8'h07, 8'h07, 0, 8'h00, 0, 0, 1, 0, 0, 0);
      add(1, 8'h99, 8'h07, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(0, 8'h02, 8'h02, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      add(1, 8'h01, 8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 0);
      add(1, 8'h02, 8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 0);
      add(0, 8'h03, 8'h03, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      add(1, 8'hCC, 8'h03, 0, 8'h00, 0, 1, 0, 1, 32'h1234567A, 32'h12345678);
      add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);
      add(0, 8'h02, 8'h02, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 8'hFF, 8'h02, 0, 8'h00, 0, (i != 3), 0, 0, 0, 0);
      add(0, 8'h03, 8'h03, 0, 8'h00, 0, 1, 1, 0, 0, 0);
      add(1, 8'h11, 8'h03, 0, 8'h00, 0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      add(1, 8'h22, 8'h03, 0, 8'h00, 0, 1, 0, 1, 32'h00000000, 32'hFFFFFFFF);
      add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);

      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check("rst_outputs", {mcu_data_out, mcu_data_oe, cmd_strobe, cmd_code, wr_valid,
                            wr_addr, overflow, busy}, 64'd0);
      check("rst_wr_data", {56'd0, wr_data}, 64'd0);
      @(posedge sysclk); #1 rst_n = 1'b1; wr_ready = 1'b1;

      foreach (vt[k]) begin
         if (vt[k].beat) exp_q.push_back({sel(vt[k].a_inc, vt[k].a_hold), vt[k].d});
         h0 = n_hi; r0 = n_rise;
         xfer(vt[k].cd, vt[k].d);
         check($sformatf("vec%0d_status", k),
               {cmd_code, mcu_data_oe, mcu_data_out, overflow, busy},
               {vt[k].code, vt[k].oe, vt[k].dout, vt[k].ovf, vt[k].bsy});
         check($sformatf("vec%0d_pulse", k), {n_hi - h0, n_rise - r0},
               {vt[k].pulses, vt[k].pulses});
      end
      drain("table_drain");

      // Backpressure: 10 beats into 8 entries, then release and clear.
      base = sel(32'h00000001, 32'hFFFFFFFF);
      wr_ready = 1'b0;
      xfer(0, 8'h03);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_q.push_back({sel(base + i, base), 8'(i + 1)});
         xfer(1, 8'(i + 1));
      end
      check("bp_full_status", {overflow, wr_valid, busy}, 3'b111);
      wr_ready = 1'b1;
      drain("bp_drain");
      xfer(0, 8'h04);
      check("bp_clear", {cmd_code, overflow, busy}, {8'h04, 2'b00});

      // Full FIFO with simultaneous push and pop.
      base = sel(base + 8, base);
      wr_ready = 1'b0;
      xfer(0, 8'h03);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({sel(base + i, base), 8'(8'h21 + i)});
         xfer(1, 8'(8'h21 + i));
      end
      check("pp_full", {overflow, wr_valid}, 2'b01);
      exp_q.push_back({sel(base + 8, base), 8'h29});
      xfer_sync_pop(8'h29);
      check("pp_no_overflow", {overflow, wr_valid}, 2'b01);
      check("pp_one_popped", exp_q.size(), 8);
      wr_ready = 1'b1;
      drain("pp_drain");

      // Reset in mid-ADDR with three beats queued.
      wr_ready = 1'b0;
      xfer(0, 8'h03);
      for (int i = 0; i < 3; i++) xfer(1, 8'(8'h31 + i));
      xfer(0, 8'h02);
      xfer(1, 8'h44);
      check("pre_rst_valid", {wr_valid, busy}, 2'b11);
      @(posedge sysclk); #1 rst_n = 1'b0;
      @(posedge sysclk); #1 rst_n = 1'b1;
      @(negedge sysclk);
      check("midrst_status", {wr_valid, busy, overflow, mcu_data_oe, cmd_code, wr_addr},
            {4'b0000, 8'h00, 32'h0});
      wr_ready = 1'b1;
      xfer(0, 8'h03);
      exp_q.push_back({32'h00000000, 8'h5A});
      xfer(1, 8'h5A);
      drain("midrst_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
